// File: rtl/traffic_pkg.sv
// Shared lamp encodings, tracker state type and error-bit layout for the
// traffic light monitor.
package traffic_pkg;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    typedef enum logic [1:0] {
        ST_RED    = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } lamp_state_t;

    localparam int ERR_W        = 5;
    localparam int ERR_ONEHOT   = 0;
    localparam int ERR_SEQUENCE = 1;
    localparam int ERR_YSHORT   = 2;
    localparam int ERR_STARVE   = 3;
    localparam int ERR_CONFLICT = 4;

    // Only meaningful for a one-hot lamp value; callers check validity first.
    function automatic lamp_state_t decode_lamp(input logic [2:0] lamp);
        lamp_state_t st;
        st = ST_RED;
        if (lamp == LAMP_G) st = ST_GREEN;
        else if (lamp == LAMP_Y) st = ST_YELLOW;
        return st;
    endfunction

    function automatic logic legal_move(input lamp_state_t from_st, input lamp_state_t to_st);
        logic ok;
        ok = (from_st == to_st) ||
             (from_st == ST_RED    && to_st == ST_GREEN)  ||
             (from_st == ST_GREEN  && to_st == ST_YELLOW) ||
             (from_st == ST_YELLOW && to_st == ST_RED);
        return ok;
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp buses into the monitor plus its error/count results and per-lamp debug view.
interface traffic_light_monitor_if #(
    parameter int CNT_W = 8
);
    import traffic_pkg::*;

    // Lamp buses carry no handshake: every clock edge is one sample of all four
    // lamps, and every result field is valid on every cycle once reset is released.
    logic [2:0]       T1;
    logic [2:0]       T2;
    logic [2:0]       S1;
    logic [2:0]       S2;
    logic             clr_sticky;
    logic [ERR_W-1:0] err_pulse;
    logic [ERR_W-1:0] err_sticky;
    logic [15:0]      main_cycles;
    lamp_state_t      dbg_state [4];
    logic [CNT_W-1:0] dbg_dwell [4];
    logic [3:0]       dbg_r2g;

    modport master (
        output T1, T2, S1, S2, clr_sticky,
        input  err_pulse, err_sticky, main_cycles, dbg_state, dbg_dwell, dbg_r2g
    );

    modport slave (
        input  T1, T2, S1, S2, clr_sticky,
        output err_pulse, err_sticky, main_cycles, dbg_state, dbg_dwell, dbg_r2g
    );

endinterface

// File: rtl/lamp_tracker.sv
// Follows one lamp's R/G/Y state and dwell time; flags encoding, sequencing,
// short-yellow and red-starvation events for the current sample.
module lamp_tracker
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 2,
    parameter int MAX_RED    = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       lamp,
    output lamp_state_t      prev,
    output lamp_state_t      cur,
    output logic             valid,
    output logic [CNT_W-1:0] dwell,
    output logic             seq,
    output logic             yshort,
    output logic             starve,
    output logic             r2g
);

    logic [CNT_W-1:0] dwell_next;

    always_comb begin
        valid      = $onehot(lamp);
        // An invalid sample is treated as "no news": state and dwell stay put.
        cur        = valid ? decode_lamp(lamp) : prev;
        dwell_next = dwell;
        if (cur != prev)
            dwell_next = CNT_W'(1);
        else if (dwell != '1)
            dwell_next = dwell + CNT_W'(1);
        seq    = valid && !legal_move(prev, cur);
        yshort = valid && prev == ST_YELLOW && cur == ST_RED && dwell < CNT_W'(MIN_YELLOW);
        // Fires only on the step onto MAX_RED, so a long red gives one pulse.
        starve = valid && cur == ST_RED && dwell_next == CNT_W'(MAX_RED) && dwell_next != dwell;
        r2g    = valid && prev == ST_RED && cur == ST_GREEN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= ST_RED;
            dwell <= '0;
        end else if (valid) begin
            prev  <= cur;
            dwell <= dwell_next;
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the four trafficcontrol lamp buses: registered error
// pulses, sticky error flags and a count of main-road red->green cycles.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 2,
    parameter int MAX_RED    = 16,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst,
    traffic_light_monitor_if.slave bus
);

    logic [2:0]       lamps    [4];
    lamp_state_t      prev_st  [4];
    lamp_state_t      cur_st   [4];
    logic [CNT_W-1:0] dwell    [4];
    logic [3:0]       valid;
    logic [3:0]       seq;
    logic [3:0]       yshort;
    logic [3:0]       starve;
    logic [3:0]       r2g;

    logic [ERR_W-1:0] err_next;
    logic [ERR_W-1:0] err_pulse_q;
    logic [ERR_W-1:0] err_sticky_q;
    logic [15:0]      main_cycles_q;
    logic             main_active;
    logic             side_active;

    // Index 0..1 are the main-road lamps, 2..3 the side-road lamps.
    assign lamps[0] = bus.T1;
    assign lamps[1] = bus.T2;
    assign lamps[2] = bus.S1;
    assign lamps[3] = bus.S2;

    for (genvar i = 0; i < 4; i++) begin : g_trk
        lamp_tracker #(
            .MIN_YELLOW (MIN_YELLOW),
            .MAX_RED    (MAX_RED),
            .CNT_W      (CNT_W)
        ) u_trk (
            .clk    (clk),
            .rst    (rst),
            .lamp   (lamps[i]),
            .prev   (prev_st[i]),
            .cur    (cur_st[i]),
            .valid  (valid[i]),
            .dwell  (dwell[i]),
            .seq    (seq[i]),
            .yshort (yshort[i]),
            .starve (starve[i]),
            .r2g    (r2g[i])
        );
        assign bus.dbg_state[i] = prev_st[i];
        assign bus.dbg_dwell[i] = dwell[i];
    end

    always_comb begin
        main_active = (valid[0] && cur_st[0] != ST_RED) || (valid[1] && cur_st[1] != ST_RED);
        side_active = (valid[2] && cur_st[2] != ST_RED) || (valid[3] && cur_st[3] != ST_RED);
        err_next               = '0;
        err_next[ERR_ONEHOT]   = ~&valid;
        err_next[ERR_SEQUENCE] = |seq;
        err_next[ERR_YSHORT]   = |yshort;
        err_next[ERR_STARVE]   = |starve;
        err_next[ERR_CONFLICT] = main_active && side_active;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse_q   <= '0;
            err_sticky_q  <= '0;
            main_cycles_q <= '0;
        end else begin
            err_pulse_q   <= err_next;
            // A fresh error on the clearing cycle survives the clear.
            err_sticky_q  <= (bus.clr_sticky ? '0 : err_sticky_q) | err_next;
            main_cycles_q <= main_cycles_q + {15'd0, r2g[0]};
        end
    end

    assign bus.err_pulse   = err_pulse_q;
    assign bus.err_sticky  = err_sticky_q;
    assign bus.main_cycles = main_cycles_q;
    assign bus.dbg_r2g     = r2g;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed scenario bench for traffic_light_monitor with hand-computed expectations.
module tb_traffic_light_monitor;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    traffic_light_monitor_if bus ();

    traffic_light_monitor #(
        .MIN_YELLOW (2),
        .MAX_RED    (16),
        .CNT_W      (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lamps(input logic [2:0] t1, input logic [2:0] t2,
                         input logic [2:0] s1, input logic [2:0] s2);
        bus.T1 = t1;
        bus.T2 = t2;
        bus.S1 = s1;
        bus.S2 = s2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.clr_sticky = 1'b0;
        lamps(R, R, R, R);
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.clr_sticky = 1'b0;
        lamps(R, R, R, R);
        step();
        step();
        checks++;
        if (bus.err_pulse !== 5'b0) begin
            errors++; $display("FAIL reset_err_pulse got %b exp %b", bus.err_pulse, 5'b0);
        end
        checks++;
        if (bus.err_sticky !== 5'b0) begin
            errors++; $display("FAIL reset_err_sticky got %b exp %b", bus.err_sticky, 5'b0);
        end
        checks++;
        if (bus.main_cycles !== 16'd0) begin
            errors++; $display("FAIL reset_main_cycles got %0d exp 0", bus.main_cycles);
        end
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (bus.err_pulse !== 5'b0) begin
                errors++; $display("FAIL idle_red_pulse cycle %0d got %b exp %b", k, bus.err_pulse, 5'b0);
            end
        end
        checks++;
        if (bus.err_sticky !== 5'b0 || bus.main_cycles !== 16'd0) begin
            errors++;
            $display("FAIL idle_red_state got sticky %b cycles %0d exp 00000 0", bus.err_sticky, bus.main_cycles);
        end
    endtask

    task automatic test_main_sequence();
        do_reset();
        lamps(G, G, R, R);
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (bus.err_pulse !== 5'b0) begin
                errors++; $display("FAIL seq_green_pulse cycle %0d got %b exp %b", k, bus.err_pulse, 5'b0);
            end
            if (k == 1) begin
                checks++;
                if (bus.main_cycles !== 16'd1) begin
                    errors++; $display("FAIL seq_main_cycles got %0d exp 1", bus.main_cycles);
                end
            end
        end
        lamps(Y, Y, R, R);
        for (int k = 1; k <= 2; k++) begin
            step();
            checks++;
            if (bus.err_pulse !== 5'b0) begin
                errors++; $display("FAIL seq_yellow_pulse cycle %0d got %b exp %b", k, bus.err_pulse, 5'b0);
            end
        end
        lamps(R, R, R, R);
        step();
        checks++;
        if (bus.err_pulse !== 5'b0) begin
            errors++; $display("FAIL seq_back_red_pulse got %b exp %b", bus.err_pulse, 5'b0);
        end
        checks++;
        if (bus.err_sticky !== 5'b0 || bus.main_cycles !== 16'd1) begin
            errors++;
            $display("FAIL seq_final got sticky %b cycles %0d exp 00000 1", bus.err_sticky, bus.main_cycles);
        end
    endtask

    task automatic test_yellow_short();
        do_reset();
        lamps(G, R, R, R);
        step();
        step();
        lamps(Y, R, R, R);
        step();
        lamps(R, R, R, R);
        step();
        checks++;
        if (bus.err_pulse !== 5'b00100) begin
            errors++; $display("FAIL yshort_pulse got %b exp %b", bus.err_pulse, 5'b00100);
        end
        step();
        checks++;
        if (bus.err_pulse !== 5'b0) begin
            errors++; $display("FAIL yshort_single got %b exp %b", bus.err_pulse, 5'b0);
        end
        checks++;
        if (bus.err_sticky !== 5'b00100) begin
            errors++; $display("FAIL yshort_sticky got %b exp %b", bus.err_sticky, 5'b00100);
        end
    endtask

    task automatic test_onehot();
        do_reset();
        lamps(R, R, 3'b011, R);
        step();
        checks++;
        if (bus.err_pulse !== 5'b00001) begin
            errors++; $display("FAIL onehot_pulse got %b exp %b", bus.err_pulse, 5'b00001);
        end
        lamps(R, R, G, R);
        step();
        checks++;
        if (bus.err_pulse !== 5'b0) begin
            errors++; $display("FAIL onehot_then_green got %b exp %b", bus.err_pulse, 5'b0);
        end
        checks++;
        if (bus.err_sticky !== 5'b00001) begin
            errors++; $display("FAIL onehot_sticky got %b exp %b", bus.err_sticky, 5'b00001);
        end
        // Invalid S1 while T1 green: S1 must not count toward a conflict.
        lamps(G, R, 3'b000, R);
        bus.clr_sticky = 1'b1;
        step();
        bus.clr_sticky = 1'b0;
        checks++;
        if (bus.err_pulse !== 5'b00001) begin
            errors++; $display("FAIL onehot_inactive got %b exp %b", bus.err_pulse, 5'b00001);
        end
        checks++;
        if (bus.err_sticky !== 5'b00001) begin
            errors++; $display("FAIL onehot_clr_set_wins got %b exp %b", bus.err_sticky, 5'b00001);
        end
        lamps(G, R, G, R);
        bus.clr_sticky = 1'b1;
        lamps(R, R, G, R);
        step();
        bus.clr_sticky = 1'b0;
        checks++;
        if (bus.err_pulse !== 5'b00010 || bus.err_sticky !== 5'b00010) begin
            errors++;
            $display("FAIL onehot_clear got pulse %b sticky %b exp 00010 00010", bus.err_pulse, bus.err_sticky);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        lamps(G, R, R, G);
        for (int k = 1; k <= 3; k++) begin
            bus.clr_sticky = (k == 3);
            step();
            checks++;
            if (bus.err_pulse !== 5'b10000) begin
                errors++; $display("FAIL conflict_pulse cycle %0d got %b exp %b", k, bus.err_pulse, 5'b10000);
            end
        end
        bus.clr_sticky = 1'b0;
        checks++;
        if (bus.err_sticky !== 5'b10000) begin
            errors++; $display("FAIL conflict_sticky got %b exp %b", bus.err_sticky, 5'b10000);
        end
        checks++;
        if (bus.main_cycles !== 16'd1) begin
            errors++; $display("FAIL conflict_main_cycles got %0d exp 1", bus.main_cycles);
        end
    endtask

    task automatic test_t2_sequence();
        do_reset();
        lamps(R, G, R, R);
        step();
        checks++;
        if (bus.err_pulse !== 5'b0 || bus.main_cycles !== 16'd0) begin
            errors++;
            $display("FAIL t2_green got pulse %b cycles %0d exp 00000 0", bus.err_pulse, bus.main_cycles);
        end
        lamps(R, Y, R, R);
        step();
        checks++;
        if (bus.err_pulse !== 5'b0) begin
            errors++; $display("FAIL t2_yellow got %b exp %b", bus.err_pulse, 5'b0);
        end
        // T2 Y->G and S2 R->Y are both illegal, and both roads are active.
        lamps(R, G, R, Y);
        step();
        checks++;
        if (bus.err_pulse !== 5'b10010) begin
            errors++; $display("FAIL t2_bad_moves got %b exp %b", bus.err_pulse, 5'b10010);
        end
    endtask

    task automatic test_starve_and_rst();
        int pulses;
        pulses = 0;
        do_reset();
        lamps(R, R, R, R);
        for (int k = 1; k <= 20; k++) begin
            step();
            checks++;
            if (bus.err_pulse !== ((k == 16) ? 5'b01000 : 5'b00000)) begin
                errors++;
                $display("FAIL starve_pulse cycle %0d got %b exp %b", k, bus.err_pulse,
                         (k == 16) ? 5'b01000 : 5'b00000);
            end
            if (bus.err_pulse[3]) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL starve_count got %0d exp 1", pulses);
        end
        lamps(G, R, R, R);
        step();
        lamps(R, R, R, R);
        step();
        checks++;
        if (bus.err_pulse !== 5'b00010) begin
            errors++; $display("FAIL g_to_r_sequence got %b exp %b", bus.err_pulse, 5'b00010);
        end
        checks++;
        if (bus.err_sticky !== 5'b01010 || bus.main_cycles !== 16'd1) begin
            errors++;
            $display("FAIL pre_rst_state got sticky %b cycles %0d exp 01010 1", bus.err_sticky, bus.main_cycles);
        end
        rst = 1'b1;
        lamps(G, R, R, G);
        step();
        rst = 1'b0;
        checks++;
        if (bus.err_pulse !== 5'b0 || bus.err_sticky !== 5'b0 || bus.main_cycles !== 16'd0) begin
            errors++;
            $display("FAIL mid_rst got pulse %b sticky %b cycles %0d exp 00000 00000 0",
                     bus.err_pulse, bus.err_sticky, bus.main_cycles);
        end
        lamps(Y, R, R, R);
        step();
        checks++;
        if (bus.err_pulse !== 5'b00010) begin
            errors++; $display("FAIL post_rst_prev_red got %b exp %b", bus.err_pulse, 5'b00010);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.clr_sticky = 1'b0;
        lamps(R, R, R, R);
        test_reset();
        test_main_sequence();
        test_yellow_short();
        test_onehot();
        test_conflict();
        test_t2_sequence();
        test_starve_and_rst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
